// File: rtl/dsp_sample_sequencer_pkg.sv
// rtl/dsp_sample_sequencer_pkg.sv - shared types and constants for the sample sequencer
//
// Package dsp_seq_pkg
//   seq_state_t : frame FSM states IDLE -> ACQ -> FILT -> LOAD
//   SRC_*       : per-channel DAC source select encoding
//   MIDSCALE    : mute word for a 12-bit DAC
//   midscale()  : mute word for an arbitrary word width
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        FILT = 2'd2,
        LOAD = 2'd3
    } seq_state_t;

    localparam logic [1:0] SRC_BYP  = 2'b00;
    localparam logic [1:0] SRC_FIR  = 2'b01;
    localparam logic [1:0] SRC_IIR  = 2'b10;
    localparam logic [1:0] SRC_MUTE = 2'b11;

    localparam logic [11:0] MIDSCALE = 12'h800;

    // Midscale of an offset-binary DAC is only the MSB set; this keeps the
    // mute word correct if the datapath width is ever changed from 12 bits.
    function automatic logic [31:0] midscale(input int dw);
        return 32'h1 << (dw - 1);
    endfunction

endpackage

// File: rtl/dsp_sample_sequencer_if.sv
// rtl/dsp_sample_sequencer_if.sv - ADC / filter / DAC bundle driven by the sample sequencer
//
// Interface dsp_sample_sequencer_if #(DW)
//   adc_start, adc_data, adc_valid      : SPI ADC capture handshake
//   filt_din, filt_en, fir_dout, iir_dout : filter feed and results
//   dac_value, dac_value1, dac_update, dac_busy : DA2 channel words and load handshake
// Modports
//   master : the sequencer side
//   slave  : the surrounding datapath (ADC receiver, filters, DA2)
interface dsp_sample_sequencer_if #(
    parameter int DW = 12
);
    logic          adc_start;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [DW-1:0] filt_din;
    logic          filt_en;
    logic [DW-1:0] fir_dout;
    logic [DW-1:0] iir_dout;
    logic [DW-1:0] dac_value;
    logic [DW-1:0] dac_value1;
    logic          dac_update;
    logic          dac_busy;

    modport master (
        output adc_start, filt_din, filt_en, dac_value, dac_value1, dac_update,
        input  adc_data, adc_valid, fir_dout, iir_dout, dac_busy
    );

    modport slave (
        input  adc_start, filt_din, filt_en, dac_value, dac_value1, dac_update,
        output adc_data, adc_valid, fir_dout, iir_dout, dac_busy
    );

endinterface

// File: rtl/dsp_sample_sequencer_tick_gen.sv
// rtl/dsp_sample_sequencer_tick_gen.sv - sample-rate tick divider
//
// Module sample_tick_gen #(DIV_W)
//   clk, rst_n : clock, asynchronous active-low reset
//   i_enable   : run the divider; low holds the counter at i_div
//   i_div      : sample period minus one, sampled only when the counter reloads
//   o_tick     : high for the cycle in which the counter sits at zero
module sample_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // Reset leaves the counter at zero so a divider enabled straight out of
    // reset ticks immediately; a disabled divider keeps reloading so the
    // first tick after enable lands a full period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || (r_cnt == '0)) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_enable && (r_cnt == '0);

endmodule

// File: rtl/dsp_sample_sequencer.sv
// rtl/dsp_sample_sequencer.sv - frame scheduler for ADC -> FIR/IIR -> DA2
//
// Module dsp_sample_sequencer #(DW, DIV_W, FILT_LAT, ACQ_TIMEOUT)
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_enable        : run sample ticks
//   i_div           : sample period minus one, in clk cycles
//   i_mode_a/b      : channel A/B source (00 ADC bypass, 01 FIR, 10 IIR, 11 mute)
//   i_clear         : clears sticky error flags and the overrun counter
//   sif (master)    : ADC capture, filter feed and DAC load handshake
//   o_busy          : a frame is in progress
//   o_overrun       : sticky, a tick was dropped because a frame was running
//   o_timeout_err   : sticky, the ADC did not answer within ACQ_TIMEOUT cycles
//   o_ovr_count     : saturating dropped-tick count
// Build option
//   OVERRUN_CNT_EN  : defined -> o_ovr_count counts dropped ticks; undefined -> tied to 0
module dsp_sample_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int DW          = 12,
    parameter int DIV_W       = 16,
    parameter int FILT_LAT    = 4,
    parameter int ACQ_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic [DIV_W-1:0]       i_div,
    input  logic [1:0]             i_mode_a,
    input  logic [1:0]             i_mode_b,
    input  logic                   i_clear,
    dsp_sample_sequencer_if.master sif,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic                   o_timeout_err,
    output logic [7:0]             o_ovr_count
);

    localparam int TW = $clog2(ACQ_TIMEOUT + 1);
    localparam int LW = $clog2(FILT_LAT + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(ACQ_TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(FILT_LAT - 1);
    localparam logic [DW-1:0] MID_WORD = DW'(midscale(DW));

    seq_state_t    r_state;
    logic [TW-1:0] r_tmo;
    logic [LW-1:0] r_lat;
    logic          r_busy;
    logic          r_adc_start;
    logic          r_filt_en;
    logic          r_dac_update;
    logic          r_overrun;
    logic          r_timeout_err;
    logic [DW-1:0] r_filt_din;
    logic [DW-1:0] r_dac_a;
    logic [DW-1:0] r_dac_b;

    logic w_tick;
    logic w_drop;

    function automatic logic [DW-1:0] src_sel(
        input logic [1:0]    mode,
        input logic [DW-1:0] byp,
        input logic [DW-1:0] fir,
        input logic [DW-1:0] iir
    );
        case (mode)
            SRC_BYP:  return byp;
            SRC_FIR:  return fir;
            SRC_IIR:  return iir;
            SRC_MUTE: return MID_WORD;
            default:  return MID_WORD;
        endcase
    endfunction

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (i_enable),
        .i_div    (i_div),
        .o_tick   (w_tick)
    );

    // Only IDLE consumes a tick; anywhere else it is lost and flagged.
    assign w_drop = w_tick && (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tmo         <= '0;
            r_lat         <= '0;
            r_busy        <= 1'b0;
            r_adc_start   <= 1'b0;
            r_filt_en     <= 1'b0;
            r_dac_update  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_filt_din    <= '0;
            r_dac_a       <= '0;
            r_dac_b       <= '0;
        end else begin
            r_adc_start  <= 1'b0;
            r_filt_en    <= 1'b0;
            r_dac_update <= 1'b0;

            // Clear is applied first so that an event set further down in
            // the same cycle overrides it.
            if (i_clear) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state     <= ACQ;
                        r_busy      <= 1'b1;
                        r_adc_start <= 1'b1;
                        r_tmo       <= '0;
                    end
                end

                ACQ: begin
                    // A valid on the last allowed cycle still completes the frame.
                    if (sif.adc_valid) begin
                        r_filt_din <= sif.adc_data;
                        r_filt_en  <= 1'b1;
                        r_lat      <= '0;
                        r_state    <= FILT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                FILT: begin
                    // First FILT cycle is the filt_en cycle, so LOAD begins
                    // FILT_LAT cycles after the strobe.
                    if (r_lat == LAT_LAST) begin
                        r_state <= LOAD;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end

                LOAD: begin
                    if (!sif.dac_busy) begin
                        r_dac_a      <= src_sel(i_mode_a, r_filt_din, sif.fir_dout, sif.iir_dout);
                        r_dac_b      <= src_sel(i_mode_b, r_filt_din, sif.fir_dout, sif.iir_dout);
                        r_dac_update <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] r_ovr_count;

    // A drop coinciding with clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_count <= 8'd0;
        end else if (w_drop) begin
            if (i_clear) begin
                r_ovr_count <= 8'd1;
            end else if (r_ovr_count != 8'hFF) begin
                r_ovr_count <= r_ovr_count + 8'd1;
            end
        end else if (i_clear) begin
            r_ovr_count <= 8'd0;
        end
    end

    assign o_ovr_count = r_ovr_count;
`else
    assign o_ovr_count = 8'd0;
`endif

    assign sif.adc_start  = r_adc_start;
    assign sif.filt_din   = r_filt_din;
    assign sif.filt_en    = r_filt_en;
    assign sif.dac_value  = r_dac_a;
    assign sif.dac_value1 = r_dac_b;
    assign sif.dac_update = r_dac_update;

    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

endmodule
